// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and access sequencer for a
// single-port, asynchronous-read RAM with a level-sensitive write strobe.
// Every RAM control and data output comes straight from a flop, so the
// RAM never sees a combinational glitch on addr, data or wr.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready
// are both high. req_ready is combinational and is high only in IDLE, and
// only for the port the round-robin picks. Request fields are sampled only
// on the transfer cycle. A requester may raise or drop valid at any time
// before it is granted. Each accepted request produces exactly one
// rsp_valid pulse to its owner, three cycles after the transfer.
module ram_arbiter #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req_valid,
    output logic                 a_req_ready,
    input  logic                 a_req_wr,
    input  logic [ADDR_SIZE-1:0] a_req_addr,
    input  logic [WORD_SIZE-1:0] a_req_wdata,
    output logic                 a_rsp_valid,
    output logic [WORD_SIZE-1:0] a_rsp_rdata,
    input  logic                 b_req_valid,
    output logic                 b_req_ready,
    input  logic                 b_req_wr,
    input  logic [ADDR_SIZE-1:0] b_req_addr,
    input  logic [WORD_SIZE-1:0] b_req_wdata,
    output logic                 b_rsp_valid,
    output logic [WORD_SIZE-1:0] b_rsp_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_wr,
    output logic                 mem_cs,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_any_valid;
    logic                 w_grant_owner;
    logic                 w_a_ready;
    logic                 w_b_ready;

    logic                 r_last_grant;
    logic                 r_owner;
    logic                 r_wr;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic                 r_mem_wr;
    logic                 r_mem_cs;
    logic                 r_a_rsp_valid;
    logic                 r_b_rsp_valid;
    logic [WORD_SIZE-1:0] r_a_rsp_rdata;
    logic [WORD_SIZE-1:0] r_b_rsp_rdata;

    // Round-robin pick, next-state and ready generation.
    always_comb begin
        w_any_valid   = a_req_valid | b_req_valid;
        w_grant_owner = OWNER_A;
        w_next_state  = r_state;
        w_a_ready     = 1'b0;
        w_b_ready     = 1'b0;

        // On contention the port that was not served last wins.
        if (a_req_valid && b_req_valid) begin
            w_grant_owner = (r_last_grant == OWNER_A) ? OWNER_B : OWNER_A;
        end else if (b_req_valid) begin
            w_grant_owner = OWNER_B;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_next_state = ST_SETUP;
                    w_a_ready    = (w_grant_owner == OWNER_A);
                    w_b_ready    = (w_grant_owner == OWNER_B);
                end
            end
            ST_SETUP:  w_next_state = ST_STROBE;
            ST_STROBE: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register; async reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture and registered RAM/response outputs, driven from the
    // next state so each output is already valid in the cycle it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= OWNER_B;
            r_owner       <= OWNER_A;
            r_wr          <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wr      <= 1'b0;
            r_mem_cs      <= 1'b0;
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_a_rsp_rdata <= '0;
            r_b_rsp_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any_valid) begin
                r_owner      <= w_grant_owner;
                r_last_grant <= w_grant_owner;
                if (w_grant_owner == OWNER_B) begin
                    r_wr        <= b_req_wr;
                    r_mem_addr  <= b_req_addr;
                    r_mem_wdata <= b_req_wdata;
                end else begin
                    r_wr        <= a_req_wr;
                    r_mem_addr  <= a_req_addr;
                    r_mem_wdata <= a_req_wdata;
                end
            end

            // cs spans SETUP..RESP; wr only in STROBE, giving setup and hold
            // around the level-sensitive write.
            r_mem_cs      <= (w_next_state != ST_IDLE);
            r_mem_wr      <= (w_next_state == ST_STROBE) && r_wr;
            r_a_rsp_valid <= (w_next_state == ST_RESP) && (r_owner == OWNER_A);
            r_b_rsp_valid <= (w_next_state == ST_RESP) && (r_owner == OWNER_B);

            // Read data is stable by the end of STROBE; only the owner's copy moves.
            if (r_state == ST_STROBE && !r_wr) begin
                if (r_owner == OWNER_A) begin
                    r_a_rsp_rdata <= mem_rdata;
                end else begin
                    r_b_rsp_rdata <= mem_rdata;
                end
            end
        end
    end

    assign a_req_ready = w_a_ready;
    assign b_req_ready = w_b_ready;
    assign a_rsp_valid = r_a_rsp_valid;
    assign b_rsp_valid = r_b_rsp_valid;
    assign a_rsp_rdata = r_a_rsp_rdata;
    assign b_rsp_rdata = r_b_rsp_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wr      = r_mem_wr;
    assign mem_cs      = r_mem_cs;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the single-port asynchronous-read RAM (addr/data_in/wr/cs, data_out = mem[addr], level-sensitive write).
- Accepts read/write requests from ports A and B over valid/ready, then serialises them onto the RAM with registered, glitch-free control.
- Address and data are held stable around the wr strobe. Each transaction returns a one-cycle response to the owning requester.

Parameters:
- ADDR_SIZE, 10, RAM address width.
- WORD_SIZE, 8, RAM data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid  in  1  port A request valid.
- a_req_ready  out  1  port A request accepted this cycle.
- a_req_wr  in  1  port A: 1 = write, 0 = read.
- a_req_addr  in  ADDR_SIZE  port A address.
- a_req_wdata  in  WORD_SIZE  port A write data.
- a_rsp_valid  out  1  port A response pulse.
- a_rsp_rdata  out  WORD_SIZE  port A read data.
- b_req_valid, b_req_ready, b_req_wr, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as port A, for port B.
- mem_addr  out  ADDR_SIZE  to RAM addr.
- mem_wdata  out  WORD_SIZE  to RAM data_in.
- mem_wr  out  1  to RAM wr.
- mem_cs  out  1  to RAM cs.
- mem_rdata  in  WORD_SIZE  from RAM data_out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, SETUP, STROBE, RESP.
- Reset (async, rst_n low):
  - state = IDLE, last_grant = B.
  - All mem_* outputs, rsp_valid, rsp_rdata and busy = 0.
  - mem_wr drops immediately, including mid-transaction; an aborted transaction produces no response.
- IDLE:
  - req_ready is combinational and high only for the granted port, only in IDLE.
  - Grant rule:
    - only A valid -> A; only B valid -> B;
    - both valid -> the port != last_grant (A wins first contention after reset).
  - On handshake: latch addr, wdata, wr and owner; update last_grant = owner; next state SETUP.
  - mem_cs = 0 and mem_wr = 0 in IDLE.
- SETUP (1 cycle):
  - mem_cs = 1, mem_addr/mem_wdata = latched values, mem_wr = 0.
- STROBE (1 cycle):
  - mem_cs = 1, address/data unchanged, mem_wr = latched wr.
  - For reads, mem_rdata is registered into the owner's rsp_rdata at the end of STROBE.
- RESP (1 cycle):
  - mem_cs = 1, mem_wr = 0, address/data still held (hold time after the write strobe).
  - Owner's rsp_valid = 1; then next state IDLE.
- Latency and throughput:
  - Handshake in cycle T -> rsp_valid in cycle T+3 for both reads and writes.
  - One transaction per 4 cycles maximum.
- Output registering:
  - All mem_* outputs, rsp_valid and rsp_rdata are registered.
  - mem_addr, mem_wdata and mem_wr change only on clk edges, so no combinational path reaches the level-sensitive RAM.
- rsp_rdata:
  - Holds its last value until the next read for that port completes.
  - Unchanged on writes; the rsp_valid pulse acknowledges the write.
  - The non-owner's rsp_rdata and rsp_valid are untouched.
- No request is accepted outside IDLE. A requester holding valid simply waits; its fields are sampled only at handshake.
- mem_addr and mem_wdata keep their last values in IDLE; mem_cs = 0 marks them don't-care.
- Back-to-back reads and writes to the same address: the write completes (RESP) before the next SETUP, so a following read returns the new data.

Test Plan:
- Reset then A write addr 0x005 data 0xA5:
  - a_req_ready in cycle 0;
  - mem_wr high only in cycle 2 with mem_addr = 0x005, mem_wdata = 0xA5;
  - a_rsp_valid in cycle 3; b_rsp_valid stays 0.
- A read addr 0x005 after the write -> a_rsp_valid at T+3 with a_rsp_rdata = 0xA5; mem_wr never asserts.
- A and B valid together for 4 transactions:
  - grants alternate A, B, A, B;
  - busy is high between each handshake and the following IDLE return;
  - each rsp_valid is routed only to the owner.
- B writes 0x3FF data 0x11, then A reads 0x3FF in the next IDLE -> a_rsp_rdata = 0x11; b_rsp_rdata unchanged.
- Assert rst_n low during STROBE of a write to 0x010 data 0x77:
  - mem_wr and mem_cs fall asynchronously;
  - no rsp_valid is produced;
  - state is IDLE after release, and the next contention grants A.
- Requester drops valid before grant (valid pulses while busy) -> no handshake, no memory activity, state stays IDLE.
